debug_step_controller: RTL and testbench

- Sequences the MIPS pipeline (fetch/decode/execute/memory/writeback) for debug.
- Host command bytes, received through the UART RX, select one of three actions:
  - free-run the pipeline;
  - single-step it one clock at a time;
  - reset it.
- After every step, and when a HALT instruction retires, the controller freezes the pipeline. It then dumps PC, cycle count and all 32 GPRs as a byte stream to the UART TX.
- While dumping, it borrows read port 1 of the register file from decode.

---
 rtl/debug_pkg.sv | 29 ++
 rtl/word_serializer.sv | 53 +++++
 rtl/debug_step_controller.sv | 155 +++++++++++++++
 tb/tb_debug_step_controller.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Purpose: shared constants, command codes and state encoding for the debug step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package debug_pkg;

    localparam int LEN            = 32;
    localparam int NB             = $clog2(LEN);
    localparam int N_REGS         = 32;
    localparam int DUMP_WORDS     = N_REGS + 2;   // PC, cycle count, then every GPR
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_IDX_W     = $clog2(DUMP_WORDS);

    localparam logic [7:0] CMD_RUN      = 8'h01;
    localparam logic [7:0] CMD_STEPMODE = 8'h02;
    localparam logic [7:0] CMD_STEP     = 8'h03;
    localparam logic [7:0] CMD_RESET    = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP_WAIT,
        ST_STEP,
        ST_DUMP_ADDR,
        ST_DUMP_LATCH,
        ST_DUMP_TX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/word_serializer.sv
// Purpose: splits one LEN-bit word into BYTES_PER_WORD bytes, LSB first, onto a valid/ready byte link.
// Latency: first byte valid the cycle after i_load; one byte per cycle while i_tx_ready is high.
// Backpressure: o_tx_data/o_tx_valid hold while i_tx_ready is low; o_done pulses with the last handshake.
// Ports: clk, i_clear (sync clear, drops any word in flight), i_load/i_word (capture a word),
//        i_tx_ready/o_tx_valid/o_tx_data (byte link), o_done (last byte accepted this cycle).
module word_serializer
    import debug_pkg::*;
(
    input  logic           clk,
    input  logic           i_clear,
    input  logic           i_load,
    input  logic [LEN-1:0] i_word,
    input  logic           i_tx_ready,
    output logic           o_tx_valid,
    output logic [7:0]     o_tx_data,
    output logic           o_done
);

    localparam int              BCW       = $clog2(BYTES_PER_WORD);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

    logic [LEN-1:0] r_shift;
    logic [BCW-1:0] r_cnt;
    logic           r_valid;
    logic           w_fire;

    assign w_fire = r_valid && i_tx_ready;

    // The word shifts right so the current byte is always the low byte; once all
    // bytes are gone the register is zero, which keeps o_tx_data quiet when idle.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_word;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_fire) begin
            r_shift <= {8'h00, r_shift[LEN-1:8]};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LAST_BYTE) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_tx_valid = r_valid;
    assign o_tx_data  = r_shift[7:0];
    assign o_done     = w_fire && (r_cnt == LAST_BYTE);

endmodule

// File: rtl/debug_step_controller.sv
// Purpose: host-commanded run/step/reset sequencing of the pipeline plus a 136-byte state dump
//          (PC, cycle count, 32 GPRs) after every step and on HALT.
// Latency: commands act on the next cycle; each dump word costs 2 cycles plus 4 byte handshakes.
// Backpressure: tx_ready low stalls the dump with tx_data held; commands other than RESET are dropped while dumping.
// Ports: clk/reset (sync, active high); cmd_valid/cmd_data (host command byte); halt_flag, in_pc,
//        reg_read_data (from the pipeline); pipe_enable/pipe_reset (pipeline control);
//        dbg_reg_sel/reg_read_addr (register file port 1 steal); tx_valid/tx_data/tx_ready (dump bytes).
module debug_step_controller
    import debug_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    input  logic [7:0]      cmd_data,
    input  logic            halt_flag,
    input  logic [LEN-1:0]  in_pc,
    input  logic [LEN-1:0]  reg_read_data,
    output logic            pipe_enable,
    output logic            pipe_reset,
    output logic            dbg_reg_sel,
    output logic [NB-1:0]   reg_read_addr,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready
);

    localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(DUMP_WORDS - 1);
    localparam logic [WORD_IDX_W-1:0] FIRST_GPR = WORD_IDX_W'(2);
    localparam logic [WORD_IDX_W-1:0] CNT_WORD  = WORD_IDX_W'(1);

    state_t                r_state;
    state_t                w_next;
    logic [LEN-1:0]        r_cycle_count;
    logic [LEN-1:0]        r_snap_pc;
    logic [LEN-1:0]        r_snap_count;
    logic [WORD_IDX_W-1:0] r_word;
    logic                  r_halt_seen;

    logic                  w_cmd_reset;
    logic                  w_last_word;
    logic                  w_dumping;
    logic                  w_ser_load;
    logic                  w_ser_clear;
    logic                  w_ser_done;
    logic [LEN-1:0]        w_ser_word;

    assign w_cmd_reset = cmd_valid && (cmd_data == CMD_RESET);
    assign w_last_word = (r_word == LAST_WORD);
    assign w_ser_clear = reset || w_cmd_reset;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        w_next = r_state;
        if (w_cmd_reset) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_data == CMD_RUN)           w_next = ST_RUN;
                    else if (cmd_valid && cmd_data == CMD_STEPMODE) w_next = ST_STEP_WAIT;
                end
                ST_RUN: begin
                    if (halt_flag) w_next = ST_DUMP_ADDR;
                end
                ST_STEP_WAIT: begin
                    if (cmd_valid && cmd_data == CMD_RUN)       w_next = ST_RUN;
                    else if (cmd_valid && cmd_data == CMD_STEP) w_next = ST_STEP;
                end
                ST_STEP:       w_next = ST_DUMP_ADDR;
                ST_DUMP_ADDR:  w_next = ST_DUMP_LATCH;
                ST_DUMP_LATCH: w_next = ST_DUMP_TX;
                ST_DUMP_TX: begin
                    if (w_ser_done) begin
                        if (!w_last_word)     w_next = ST_DUMP_ADDR;
                        else if (r_halt_seen) w_next = ST_DONE;
                        else                  w_next = ST_STEP_WAIT;
                    end
                end
                ST_DONE:  w_next = ST_DONE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        pipe_reset    = (r_state == ST_IDLE);
        pipe_enable   = (r_state == ST_RUN) || (r_state == ST_STEP);
        w_dumping     = (r_state == ST_DUMP_ADDR) || (r_state == ST_DUMP_LATCH) ||
                        (r_state == ST_DUMP_TX);
        dbg_reg_sel   = w_dumping;
        reg_read_addr = '0;
        if (w_dumping && r_word >= FIRST_GPR) begin
            reg_read_addr = NB'(r_word - FIRST_GPR);
        end
        w_ser_load    = (r_state == ST_DUMP_LATCH);
    end

    // The register file answers one cycle after the address, so the GPR is read
    // in DUMP_LATCH from the address driven during DUMP_ADDR.
    always_comb begin
        if (r_word == '0)            w_ser_word = r_snap_pc;
        else if (r_word == CNT_WORD) w_ser_word = r_snap_count;
        else                         w_ser_word = reg_read_data;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset || w_cmd_reset) begin
            r_cycle_count <= '0;
            r_snap_pc     <= '0;
            r_snap_count  <= '0;
            r_word        <= '0;
            r_halt_seen   <= 1'b0;
        end else begin
            if (pipe_enable) begin
                r_cycle_count <= r_cycle_count + 1'b1;
                // Sticky: a HALT always ends in DONE, which only a reset leaves.
                if (halt_flag) begin
                    r_halt_seen <= 1'b1;
                end
            end
            // First DUMP_ADDR cycle: the pipeline is already frozen, so PC and
            // count include the final enabled cycle.
            if (r_state == ST_DUMP_ADDR && r_word == '0) begin
                r_snap_pc    <= in_pc;
                r_snap_count <= r_cycle_count;
            end
            if (r_state == ST_DUMP_TX && w_ser_done) begin
                r_word <= w_last_word ? '0 : r_word + 1'b1;
            end
        end
    end

    word_serializer u_ser (
        .clk        (clk),
        .i_clear    (w_ser_clear),
        .i_load     (w_ser_load),
        .i_word     (w_ser_word),
        .i_tx_ready (tx_ready),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .o_done     (w_ser_done)
    );

endmodule

// File: tb/tb_debug_step_controller.sv
// Purpose: randomized bench for debug_step_controller against a mode/byte-queue reference model.
// Latency: n/a.
// Backpressure: tx_ready is randomized during selected dumps.
module tb_debug_step_controller;
    import debug_pkg::*;

    localparam logic [31:0] PC_BASE = 32'h0000_1000;
    localparam int M_IDLE = 0, M_RUN = 1, M_SW = 2, M_STEP = 3, M_DUMP = 4, M_DONE = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic [7:0]      cmd_data;
    logic            halt_flag;
    logic [LEN-1:0]  in_pc = '0;
    logic [LEN-1:0]  reg_read_data = '0;
    logic            pipe_enable;
    logic            pipe_reset;
    logic            dbg_reg_sel;
    logic [NB-1:0]   reg_read_addr;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            tx_ready;

    always #5 clk = ~clk;

    debug_step_controller dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .halt_flag     (halt_flag),
        .in_pc         (in_pc),
        .reg_read_data (reg_read_data),
        .pipe_enable   (pipe_enable),
        .pipe_reset    (pipe_reset),
        .dbg_reg_sel   (dbg_reg_sel),
        .reg_read_addr (reg_read_addr),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready)
    );

    // ---------------- pipeline / register file environment ----------------
    logic [31:0] gpr [N_REGS];
    logic [NB-1:0] dec_addr = '0;

    always @(posedge clk) begin
        if (pipe_reset)       in_pc <= PC_BASE;
        else if (pipe_enable) in_pc <= in_pc + 32'd4;
        reg_read_data <= gpr[dbg_reg_sel ? reg_read_addr : dec_addr];
        dec_addr      <= NB'($urandom);
    end

    // ---------------- scoring ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode = M_IDLE;
    int          m_after = M_SW;
    logic [31:0] m_count = '0;
    logic [7:0]  m_q[$];
    logic [7:0]  log_q[$];
    bit          model_on = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = '0;
    logic        acc;
    int          en_total = 0;

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) m_q.push_back(w[8*b +: 8]);
    endtask

    task automatic start_dump(input int after);
        m_q.delete();
        log_q.delete();
        push_word(PC_BASE + 32'd4 * m_count);
        push_word(m_count);
        for (int r = 0; r < N_REGS; r++) push_word(gpr[r]);
        m_mode  = M_DUMP;
        m_after = after;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("pipe_reset", pipe_reset, m_mode == M_IDLE);
            check("pipe_enable", pipe_enable, m_mode == M_RUN || m_mode == M_STEP);
            check("dbg_reg_sel", dbg_reg_sel, m_mode == M_DUMP);
            if (m_mode != M_DUMP) check("tx_idle", tx_valid, 0);
            else if (tx_valid) begin
                if (m_q.size() == 0) check("tx_overrun", tx_valid, 0);
                else                 check("tx_data", tx_data, m_q[0]);
            end
            if (prev_stall) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, prev_data);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (pipe_enable) en_total++;

            acc = tx_valid && tx_ready;
            if (acc && m_mode == M_DUMP && m_q.size() > 0) begin
                log_q.push_back(m_q[0]);
                void'(m_q.pop_front());
            end
            if (cmd_valid && cmd_data == CMD_RESET) begin
                m_mode  = M_IDLE;
                m_count = '0;
                m_q.delete();
                prev_stall = 0;
            end else begin
                case (m_mode)
                    M_IDLE: begin
                        if (cmd_valid && cmd_data == CMD_RUN)           m_mode = M_RUN;
                        else if (cmd_valid && cmd_data == CMD_STEPMODE) m_mode = M_SW;
                    end
                    M_RUN: begin
                        m_count = m_count + 1;
                        if (halt_flag) start_dump(M_DONE);
                    end
                    M_SW: begin
                        if (cmd_valid && cmd_data == CMD_RUN)       m_mode = M_RUN;
                        else if (cmd_valid && cmd_data == CMD_STEP) m_mode = M_STEP;
                    end
                    M_STEP: begin
                        m_count = m_count + 1;
                        start_dump(halt_flag ? M_DONE : M_SW);
                    end
                    M_DUMP: if (acc && m_q.size() == 0) m_mode = m_after;
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [31:0] word_at(input int i);
        if (log_q.size() < 4*i + 4) return 32'hxxxx_xxxx;
        return {log_q[4*i+3], log_q[4*i+2], log_q[4*i+1], log_q[4*i]};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd_data  = c;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    // Raise halt_flag during the n-th enabled cycle; optionally poke CMD_STEP mid-run.
    task automatic run_to_halt(input int n, input bit poke_step);
        int en = 0;
        send(CMD_RUN);
        for (int c = 0; c < 200; c++) begin
            cmd_valid = 1'b0;
            if (pipe_enable) en++;
            if (en == n) begin
                halt_flag = 1'b1;
                tick();
                halt_flag = 1'b0;
                return;
            end
            if (poke_step && en == 3) begin
                cmd_valid = 1'b1;
                cmd_data  = CMD_STEP;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("halt_reached", en, n);
    endtask

    task automatic wait_dump(input bit rnd_ready, input int reset_at, input int run_at);
        bit sent_r = 0;
        bit sent_run = 0;
        for (int c = 0; c < 3000 && (m_mode == M_DUMP || m_mode == M_STEP); c++) begin
            cmd_valid = 1'b0;
            tx_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            halt_flag = pipe_enable ? 1'b0 : 1'($urandom_range(0, 1));
            if (!sent_r && reset_at >= 0 && log_q.size() >= reset_at) begin
                cmd_valid = 1'b1; cmd_data = CMD_RESET; sent_r = 1;
            end else if (!sent_run && run_at >= 0 && log_q.size() >= run_at) begin
                cmd_valid = 1'b1; cmd_data = CMD_RUN; sent_run = 1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        halt_flag = 1'b0;
        tx_ready  = 1'b1;
        check("dump_finished", m_mode == M_DUMP || m_mode == M_STEP, 0);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] log1[$];

    initial begin
        int ndiff;
        int e0;
        for (int r = 0; r < N_REGS; r++) gpr[r] = $urandom;
        gpr[5] = 32'hDEAD_BEEF;
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00; halt_flag = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_on = 1;
        check("rst_pipe_reset", pipe_reset, 1);
        check("rst_pipe_enable", pipe_enable, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_dbg_reg_sel", dbg_reg_sel, 0);
        check("rst_reg_read_addr", reg_read_addr, 0);
        send(8'hFF);
        send(CMD_STEP);

        // Free run, HALT on the 10th enabled cycle, CMD_STEP poked mid-run.
        run_to_halt(10, 1);
        wait_dump(0, -1, -1);
        check("run_len", log_q.size(), 136);
        check("run_pc", word_at(0), PC_BASE + 32'd40);
        check("run_count", word_at(1), 32'h0000_000A);
        check("run_r5", word_at(7), 32'hDEAD_BEEF);
        log1 = log_q;
        send(CMD_STEP);
        send(CMD_RUN);
        send(CMD_STEPMODE);
        tick();
        check("done_frozen", pipe_enable, 0);
        check("done_not_idle", pipe_reset, 0);

        // Same run with random backpressure must give the identical stream.
        send(CMD_RESET);
        check("cmdrst_pipe_reset", pipe_reset, 1);
        run_to_halt(10, 0);
        wait_dump(1, -1, -1);
        check("rnd_len", log_q.size(), 136);
        ndiff = 0;
        for (int i = 0; i < 136; i++)
            if (i >= log_q.size() || log_q[i] !== log1[i]) ndiff++;
        check("stream_match", ndiff, 0);

        // Step mode: three single steps, CMD_RUN dropped during the second dump.
        send(CMD_RESET);
        send(CMD_STEPMODE);
        send(8'hFF);
        e0 = en_total;
        for (int k = 1; k <= 3; k++) begin
            send(CMD_STEP);
            wait_dump(1, -1, (k == 2) ? 20 : -1);
            check("step_count", word_at(1), k);
            check("step_pc", word_at(0), PC_BASE + 32'd4 * k);
            tick();
            check("step_wait_frozen", pipe_enable, 0);
        end
        check("step_pulses", en_total - e0, 3);

        // Step that retires HALT ends in DONE.
        send(CMD_STEP);
        halt_flag = 1'b1;
        tick();
        halt_flag = 1'b0;
        wait_dump(0, -1, -1);
        check("halt_step_count", word_at(1), 32'd4);
        send(CMD_STEP);
        tick();
        check("halt_step_done", pipe_enable, 0);

        // CMD_RESET after 50 dump bytes abandons the dump; restart is clean.
        send(CMD_RESET);
        run_to_halt(7, 0);
        wait_dump(1, 50, -1);
        check("midrst_tx_valid", tx_valid, 0);
        check("midrst_pipe_reset", pipe_reset, 1);
        check("midrst_dbg_reg_sel", dbg_reg_sel, 0);
        tick();
        run_to_halt(3, 0);
        wait_dump(0, -1, -1);
        check("restart_count", word_at(1), 32'd3);
        check("restart_pc", word_at(0), PC_BASE + 32'd12);
        check("restart_len", log_q.size(), 136);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish, expected finish before 600000");
        $fatal(1, "watchdog expired");
    end

endmodule
